dsp_mac_pipe: RTL
=================

Name: dsp_mac_pipe

Overview:
- Parametrised, DSP48A1-style streaming multiply-accumulate engine for the synth filter datapath (IIR/LPF taps).
- Pipeline: A/B input registers, M (product) register, P accumulator register, output register with rounding and saturation.
- Operand widths, accumulator width, output width and shift are generic.
- Valid/ready handshake on both sides with full-pipeline stall, per-beat add/subtract, and first/last framing of accumulation runs.

Parameters:
- A_W, 18, signed width of operand A
- B_W, 18, signed width of operand B
- ACC_W, 48, accumulator (P) width; must be >= A_W+B_W
- OUT_W, 24, width of rounded/saturated result
- SHIFT, 17, arithmetic right shift applied to P for out_data (0 allowed)
- SATURATE, 1, 1 = clamp out_data to OUT_W range; 0 = truncate (wrap)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_a  in  A_W  signed operand A
- in_b  in  B_W  signed operand B
- in_first  in  1  beat starts a new run: P loads ±product instead of accumulating
- in_last  in  1  beat ends a run: produces a result
- in_sub  in  1  product is subtracted (1) or added (0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  rounded, shifted, saturated result
- out_acc  out  ACC_W  raw P value of the run
- out_ovf  out  1  out_data was clamped (or would be, when SATURATE=0)

Behaviour:
- Reset (reset low, async): all stage valids 0, P=0, out_valid=0, out_data=0, out_acc=0, out_ovf=0. in_ready goes 1 after reset is released. Partial sums are discarded.
- Global enable: en = !(out_valid && !out_ready). in_ready = en. Every pipeline register advances only when en=1.
- Stage 1 (on en): register a, b, first, last, sub and valid=in_valid&&in_ready.
- Stage 2: M = a*b, signed, width A_W+B_W, sign-extended to ACC_W. Control bits travel along with M.
- Stage 3, when the stage-2 valid is set:
  - first=1: P = sub ? −M : M
  - first=0: P = P ± M
  - Arithmetic wraps modulo 2^ACC_W, as in the DSP slice.
  - A bubble (valid=0) leaves P unchanged.
  - A beat without first after a completed run continues accumulating from the held P.
- Stage 4: when the stage-3 beat has last=1:
  - out_acc = P.
  - r = (P + (SHIFT>0 ? 2^(SHIFT−1) : 0)) >>> SHIFT, computed in ACC_W+1 bits. Rounding is half toward +inf.
  - out_data = r clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1] if SATURATE, else r[OUT_W−1:0].
  - out_ovf = 1 if r is out of range.
  - out_valid is set.
- out_valid clears on a handshake with no new last beat arriving. A back-to-back last beat replaces the output in the same cycle as the handshake.
- Latency: a last beat accepted on edge N makes out_valid=1 after edge N+3, i.e. 4 cycles from accept to visible result with no stall.
- Throughput is 1 beat/cycle. Single-beat runs (first=last=1) are legal every cycle.
- Stall: while out_valid && !out_ready, no stage advances, P holds, in_ready=0. No beat is lost or duplicated.
- A beat with first=1 while a run is open silently starts a new run. The previous partial sum is dropped, with no result.
- in_valid=0 with in_ready=1 injects a bubble. Framing bits are ignored on non-valid cycles.

Test Plan:
- Defaults; one beat a=16384, b=16, first=last=1 → exactly 4 cycles later out_valid=1, out_acc=262144, out_data=2, out_ovf=0.
- Defaults; a=1, b=65536, first=last=1 → out_acc=65536, out_data=1 (half rounds up). Then a=−1, b=65536 → out_data=0.
- SHIFT=0; run (100,200,first), (50,40,sub), (−3,7,last) fed back-to-back → single result out_data=17979, out_acc=17979; no out_valid on the first two beats.
- SHIFT=0, OUT_W=16, SATURATE=1; a=b=−131072 → out_acc=17179869184, out_data=32767, out_ovf=1. a=−131072, b=131071 → out_data=−32768, out_ovf=1.
- Backpressure: five single-beat runs of 1..5 (a=k, b=1, SHIFT=0) with out_ready held low for 6 cycles, then high → in_ready drops while result 1 is held; results 1,2,3,4,5 are delivered in order, each exactly once.
- Reset mid-run: assert reset after two beats of an open run, release, then send (7,3,first,last) with SHIFT=0 → outputs zero during reset; next result is 21, with no stale accumulation.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Streaming multiply-accumulate engine (A/B regs -> M reg -> P accumulator -> rounded/saturated output reg).
// Latency: a last beat accepted on edge N shows out_valid after edge N+3; throughput is 1 beat/cycle.
// Backpressure: a held result (out_valid && !out_ready) freezes every stage and drops in_ready.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   in_valid/in_ready          input beat handshake; in_a, in_b signed operands
//   in_first/in_last/in_sub    run framing (load vs accumulate, emit result) and add/subtract select
//   out_valid/out_ready        result handshake
//   out_data                   P rounded half-up, shifted right by SHIFT, saturated (or wrapped) to OUT_W
//   out_acc                    raw P of the run; out_ovf flags that out_data left the OUT_W range
`timescale 1ns/1ps
module dsp_mac_pipe #(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int ACC_W    = 48,
  parameter int OUT_W    = 24,
  parameter int SHIFT    = 17,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a,
  input  logic signed [B_W-1:0]   in_b,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf
);

  localparam int PROD_W  = A_W + B_W;
  // Bit position of the half-LSB rounding constant; irrelevant when SHIFT is 0.
  localparam int RND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;

  // Representable OUT_W range, expressed in the ACC_W+1 bit rounding domain.
  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef struct packed {
    logic first;
    logic last;
    logic sub;
  } ctl_t;

  // Single pipeline-wide enable: nothing moves while a result is held.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // ---------------- Stage 1: operand / control registers ----------------
  logic                  v1;
  logic signed [A_W-1:0] a1;
  logic signed [B_W-1:0] b1;
  ctl_t                  c1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      c1 <= '0;
    end else if (en) begin
      v1 <= in_valid;
      a1 <= in_a;
      b1 <= in_b;
      // Framing bits are meaningless on idle cycles; keep them quiet.
      c1 <= in_valid ? ctl_t'{first: in_first, last: in_last, sub: in_sub} : '0;
    end
  end

  // ---------------- Stage 2: product register ----------------
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] m2;
  logic                     v2;
  ctl_t                     c2;

  // Operands widened first so the multiply is carried out at full product width.
  assign prod = PROD_W'(a1) * PROD_W'(b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2 <= 1'b0;
      m2 <= '0;
      c2 <= '0;
    end else if (en) begin
      v2 <= v1;
      m2 <= prod;
      c2 <= c1;
    end
  end

  // ---------------- Stage 3: accumulator ----------------
  logic signed [ACC_W-1:0] m_ext;
  logic signed [ACC_W-1:0] p;
  logic signed [ACC_W-1:0] p_base;
  logic signed [ACC_W-1:0] p_nxt;
  logic                    l3;

  assign m_ext = ACC_W'(m2);

  always_comb begin
    // A first beat discards whatever partial sum is open.
    p_base = c2.first ? '0 : p;
    p_nxt  = c2.sub ? (p_base - m_ext) : (p_base + m_ext);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p  <= '0;
      l3 <= 1'b0;
    end else if (en) begin
      l3 <= v2 && c2.last;
      if (v2) begin
        p <= p_nxt;
      end
    end
  end

  // ---------------- Stage 4: round, shift, saturate ----------------
  logic [ACC_W:0]          rnd;
  logic [ACC_W:0]          p_rnd;
  logic signed [ACC_W:0]   r;
  logic                    ovf_c;
  logic signed [OUT_W-1:0] dat_c;

  always_comb begin
    rnd          = '0;
    rnd[RND_BIT] = (SHIFT > 0);
    // One extra bit so adding the rounding constant can never wrap.
    p_rnd        = {p[ACC_W-1], p} + rnd;
    r            = $signed(p_rnd) >>> SHIFT;
    ovf_c        = (r > OUT_MAX) || (r < OUT_MIN);
    dat_c        = r[OUT_W-1:0];
    if (SATURATE) begin
      if (r > OUT_MAX) begin
        dat_c = {1'b0, {(OUT_W - 1){1'b1}}};
      end else if (r < OUT_MIN) begin
        dat_c = {1'b1, {(OUT_W - 1){1'b0}}};
      end
    end
  end

  // With en high, a set out_valid implies out_ready, so "no new last beat" is
  // exactly the clear-on-handshake case; a new last beat overwrites in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (l3) begin
        out_valid <= 1'b1;
        out_acc   <= p;
        out_data  <= dat_c;
        out_ovf   <= ovf_c;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
